// File: rtl/link_pattern_checker.sv
// Loopback pattern checker: locks to fixed-word, counter or PRBS-31 streams and counts words/errors while locked.
// Optional macro BIT_ERR_COUNT_EN adds a saturating bit_err_count output.
`timescale 1ns/1ps
module link_pattern_checker #(
    parameter int unsigned LOCK_COUNT   = 16,
    parameter int unsigned UNLOCK_COUNT = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk40,
    input  logic             rstb,
    input  logic [31:0]      data_in,
    input  logic [1:0]       mode_in,
    input  logic [31:0]      pattern_word,
    input  logic             clear_counters,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count
`ifdef BIT_ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0] bit_err_count
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RUN_W  = 8;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          mode_q;
    logic [1:0]          mode_r;
    logic [DATA_W-1:0]   ref_word;
    logic [RUN_W-1:0]    good_run;
    logic [RUN_W-1:0]    bad_run;

    logic [DATA_W-1:0]   exp_word;
    logic                match;
    logic                mode_change;
    logic [RUN_W-1:0]    good_nxt;
    logic [RUN_W-1:0]    bad_nxt;
    logic [CNT_W-1:0]    word_inc;
    logic [CNT_W-1:0]    err_inc;

    // Next 32 stream bits after r (bit31 sent first), s[k] = s[k-31] ^ s[k-28].
    function automatic logic [DATA_W-1:0] prbs31_next(input logic [DATA_W-1:0] r);
        logic [2*DATA_W-1:0] seq;
        logic [DATA_W-1:0]   res;
        seq = '0;
        res = '0;
        for (int j = 0; j < 32; j++) seq[j] = r[31-j];
        for (int i = 0; i < 32; i++) seq[32+i] = seq[i+1] ^ seq[i+4];
        for (int i = 0; i < 32; i++) res[31-i] = seq[32+i];
        return res;
    endfunction

    always_comb begin
        exp_word = pattern_word;
        case (mode_q)
            2'd2:    exp_word = ref_word + DATA_W'(1);
            2'd3:    exp_word = prbs31_next(ref_word);
            default: exp_word = pattern_word;
        endcase
        match       = (data_q == exp_word);
        mode_change = (mode_q != mode_r);
        good_nxt    = good_run + RUN_W'(1);
        bad_nxt     = bad_run + RUN_W'(1);
        word_inc    = (word_count == '1) ? word_count : word_count + CNT_W'(1);
        err_inc     = (err_count == '1) ? err_count : err_count + CNT_W'(1);
    end

`ifdef BIT_ERR_COUNT_EN
    localparam int unsigned SUM_W = CNT_W + 1;
    logic [5:0]       bit_pop;
    logic [SUM_W-1:0] bit_sum;
    logic [CNT_W-1:0] bit_inc;

    // Saturating accumulate of differing bits in the current word.
    always_comb begin
        bit_pop = 6'($countones(data_q ^ exp_word));
        bit_sum = {1'b0, bit_err_count} + SUM_W'(bit_pop);
        bit_inc = bit_sum[SUM_W-1] ? '1 : bit_sum[CNT_W-1:0];
    end
`endif

    always_ff @(posedge clk40 or negedge rstb) begin
        if (!rstb) begin
            state      <= ST_OFF;
            data_q     <= '0;
            mode_q     <= '0;
            mode_r     <= '0;
            ref_word   <= '0;
            good_run   <= '0;
            bad_run    <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            word_count <= '0;
            err_count  <= '0;
`ifdef BIT_ERR_COUNT_EN
            bit_err_count <= '0;
`endif
        end else begin
            data_q    <= data_in;
            mode_q    <= mode_in;
            mode_r    <= mode_q;
            err_pulse <= 1'b0;

            if (mode_change) begin
                state    <= (mode_q == 2'd0) ? ST_OFF : ST_SEARCH;
                locked   <= 1'b0;
                good_run <= '0;
                bad_run  <= '0;
                ref_word <= data_q;
            end else begin
                case (state)
                    ST_SEARCH: begin
                        ref_word <= data_q;
                        if (!match) begin
                            good_run <= '0;
                        end else if (good_nxt == RUN_W'(LOCK_COUNT)) begin
                            state    <= ST_LOCKED;
                            locked   <= 1'b1;
                            good_run <= '0;
                        end else begin
                            good_run <= good_nxt;
                        end
                    end
                    ST_LOCKED: begin
                        // Free-running reference so a single bad word costs a single error.
                        ref_word   <= exp_word;
                        word_count <= word_inc;
                        if (match) begin
                            bad_run <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            err_count <= err_inc;
`ifdef BIT_ERR_COUNT_EN
                            bit_err_count <= bit_inc;
`endif
                            if (bad_nxt == RUN_W'(UNLOCK_COUNT)) begin
                                state   <= ST_SEARCH;
                                locked  <= 1'b0;
                                bad_run <= '0;
                            end else begin
                                bad_run <= bad_nxt;
                            end
                        end
                    end
                    default: begin
                        state    <= ST_OFF;
                        locked   <= 1'b0;
                        good_run <= '0;
                        bad_run  <= '0;
                    end
                endcase
            end

            if (clear_counters) begin
                word_count <= '0;
                err_count  <= '0;
`ifdef BIT_ERR_COUNT_EN
                bit_err_count <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_link_pattern_checker.sv
// Directed bench for link_pattern_checker: fixed, counter and PRBS-31 locking, error counting, clear and reset.
`timescale 1ns/1ps
module tb_link_pattern_checker;

    localparam logic [31:0] PAT = 32'hACCE55ED;

    logic        clk40 = 1'b0;
    logic        rstb;
    logic [31:0] data_in;
    logic [1:0]  mode_in;
    logic [31:0] pattern_word;
    logic        clear_counters;
    logic        locked;
    logic        err_pulse;
    logic [31:0] word_count;
    logic [31:0] err_count;
`ifdef BIT_ERR_COUNT_EN
    logic [31:0] bit_err_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [30:0] prbs_h;

    link_pattern_checker dut (
        .clk40         (clk40),
        .rstb          (rstb),
        .data_in       (data_in),
        .mode_in       (mode_in),
        .pattern_word  (pattern_word),
        .clear_counters(clear_counters),
        .locked        (locked),
        .err_pulse     (err_pulse),
        .word_count    (word_count),
        .err_count     (err_count)
`ifdef BIT_ERR_COUNT_EN
        ,
        .bit_err_count (bit_err_count)
`endif
    );

    always #12 clk40 = ~clk40;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input logic [31:0] d);
        data_in = d;
        @(posedge clk40);
        #1;
    endtask

    // Serial PRBS-31 source: h[0] is the newest bit, words are filled MSB first.
    task automatic prbs_word(output logic [31:0] w);
        logic nb;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            nb     = prbs_h[30] ^ prbs_h[27];
            prbs_h = {prbs_h[29:0], nb};
            w      = {w[30:0], nb};
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        rstb           = 1'b0;
        data_in        = '0;
        mode_in        = 2'd0;
        pattern_word   = PAT;
        clear_counters = 1'b0;
        prbs_h         = '1;
        repeat (2) @(posedge clk40);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_err_count", err_count, 0);
        rstb = 1'b1;
        tick(32'h0);
        tick(PAT);
        chk("off_locked", locked, 0);

        // 1: fixed word lock
        mode_in = 2'd1;
        repeat (3) tick(32'h0);
        chk("search_no_pulse", err_pulse, 0);
        chk("search_no_err", err_count, 0);
        repeat (16) tick(PAT);
        chk("t1_not_yet", locked, 0);
        tick(PAT);
        chk("t1_locked", locked, 1);
        chk("t1_wc0", word_count, 0);
        repeat (4) tick(PAT);
        chk("t1_wc4", word_count, 4);
        chk("t1_err0", err_count, 0);

        // 2: single bad word
        tick(32'hACCE55EC);
        chk("t2_pulse_early", err_pulse, 0);
        tick(PAT);
        chk("t2_pulse", err_pulse, 1);
        chk("t2_err1", err_count, 1);
        chk("t2_wc6", word_count, 6);
`ifdef BIT_ERR_COUNT_EN
        chk("t2_bit_err", bit_err_count, 1);
`endif
        tick(PAT);
        chk("t2_pulse_gone", err_pulse, 0);
        chk("t2_still_locked", locked, 1);

        // 4: four bad words unlock, then relock
        repeat (4) tick(32'h0);
        chk("t4_locked_3bad", locked, 1);
        chk("t4_err4", err_count, 4);
        tick(PAT);
        chk("t4_unlocked", locked, 0);
        chk("t4_err5", err_count, 5);
        chk("t4_wc12", word_count, 12);
`ifdef BIT_ERR_COUNT_EN
        chk("t4_bit_err", bit_err_count, 77);
`endif
        repeat (15) tick(PAT);
        chk("t4_relock_early", locked, 0);
        tick(PAT);
        chk("t4_relocked", locked, 1);
        chk("t4_wc_hold", word_count, 12);

        // 3: counter mode with one corrupted word
        mode_in = 2'd2;
        for (int v = 0; v <= 62; v++) begin
            tick((v == 40) ? 32'hFFFF_FFFF : 32'(v));
            if (v == 16) chk("t3_not_yet", locked, 0);
            if (v == 17) begin
                chk("t3_locked", locked, 1);
                chk("t3_wc13", word_count, 13);
            end
            if (v == 40) chk("t3_err_before", err_count, 5);
            if (v == 41) begin
                chk("t3_pulse", err_pulse, 1);
                chk("t3_err6", err_count, 6);
            end
            if (v == 42) chk("t3_pulse_gone", err_pulse, 0);
        end
        chk("t3_wc58", word_count, 58);
        chk("t3_err_final", err_count, 6);
        chk("t3_locked_end", locked, 1);
        clear_counters = 1'b1;
        tick(32'd63);
        clear_counters = 1'b0;
        chk("clr_wc", word_count, 0);
        chk("clr_err", err_count, 0);
        chk("clr_keeps_lock", locked, 1);
`ifdef BIT_ERR_COUNT_EN
        chk("clr_bit_err", bit_err_count, 0);
`endif

        // 5: PRBS-31 from all-ones seed
        mode_in = 2'd3;
        for (int k = 1; k <= 18; k++) begin
            prbs_word(w);
            tick(w);
            if (k == 17) chk("t5_not_yet", locked, 0);
        end
        chk("t5_locked", locked, 1);
        chk("t5_wc1", word_count, 1);
        for (int k = 0; k < 1000; k++) begin
            prbs_word(w);
            tick(w);
        end
        chk("t5_wc1001", word_count, 1001);
        chk("t5_err0", err_count, 0);
        chk("t5_locked_end", locked, 1);
        prbs_word(w);
        tick(w ^ 32'h1);
        prbs_word(w);
        clear_counters = 1'b1;
        tick(w);
        clear_counters = 1'b0;
        chk("t5_clr_err", err_count, 0);
        chk("t5_clr_wc", word_count, 0);
        prbs_word(w);
        tick(w);
        chk("t5_after_wc", word_count, 1);
        chk("t5_after_err", err_count, 0);

        // 6: reset while locked with errors pending
        for (int i = 0; i < 5; i++) begin
            prbs_word(w);
            tick(w ^ 32'h8000_0000);
            prbs_word(w);
            tick(w);
        end
        chk("t6_err5", err_count, 5);
        chk("t6_pulse", err_pulse, 1);
        chk("t6_locked", locked, 1);
        #2 rstb = 1'b0;
        #1;
        chk("t6_rst_locked", locked, 0);
        chk("t6_rst_err", err_count, 0);
        chk("t6_rst_pulse", err_pulse, 0);
        chk("t6_rst_wc", word_count, 0);
        #2 rstb = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            prbs_word(w);
            tick(w);
            if (k == 17) chk("t6_relock_early", locked, 0);
        end
        chk("t6_relocked", locked, 1);
        chk("t6_err_after", err_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
